battlefront_calc: RTL
=====================

BATTLEFRONT_CALC -- requirements
Module: battlefront_calc

Interface
REQ-001 Parameters SHALL be: N_UNITS, default 4, number of friendly slots and of enemy slots; TICK_DIV, default 8, IDLE cycles per combat round (must be at least 2).
REQ-002 Port clk SHALL be an input, 1 bit: the single system clock, rising-edge.
REQ-003 Port reset SHALL be an input, 1 bit: reset that is synchronous and active-high.
REQ-004 Port run SHALL be an input, 1 bit: when high, the round timer advances.
REQ-005 Port unitPosition SHALL be an input, N_UNITS*9 bits: friendly positions, slot i at bits [9i+8:9i].
REQ-006 Port unitType SHALL be an input, N_UNITS*2 bits: friendly types; 2'b00 means the slot is dead.
REQ-007 Port unitDamageOut SHALL be an input, N_UNITS*8 bits: friendly attack outputs.
REQ-008 Ports enemyPosition, enemyType and enemyDamageOut SHALL be inputs with the same widths and meanings, for enemy slots.
REQ-009 Port enemyFront SHALL be an output, 9 bits: the highest position among alive enemies.
REQ-010 Port unitFront SHALL be an output, 9 bits: the lowest position among alive friendlies.
REQ-011 Ports unitDamageIn and enemyDamageIn SHALL be outputs, 8 bits each: the damage applied to the frontmost friendly and to the frontmost enemy, respectively.
REQ-012 Ports unitHit and enemyHit SHALL be outputs, N_UNITS bits each: one-hot selects of the frontmost slot, or all zero.
REQ-013 Ports damageSCEN and moveSCEN SHALL be outputs, 1 bit each: single-cycle strobes consumed by every slot.

Function
REQ-014 The FSM SHALL have the states IDLE, SCAN, APPLY and MOVE, and all outputs SHALL be registered.
REQ-015 In IDLE, the counter SHALL increment only while run=1 and SHALL hold while run=0; when counter=TICK_DIV-1 and run=1, the FSM SHALL go to SCAN with counter<=0 and idx<=0.
REQ-016 SCAN SHALL examine one slot pair per cycle, idx 0..N_UNITS-1, and SHALL go to APPLY after slot N_UNITS-1, so SCAN lasts exactly N_UNITS cycles.
REQ-017 Per alive enemy, SCAN SHALL update the max enemy position and its index; on a tie the lower index SHALL be kept (strict > compare).
REQ-018 Per alive friendly, SCAN SHALL update the min friendly position and its index; on a tie the lower index SHALL be kept (strict < compare).
REQ-019 SCAN SHALL add enemyDamageOut of every alive enemy into the friendly-damage accumulator, 8 bits, saturating at 8'hFF.
REQ-020 SCAN SHALL add unitDamageOut of every alive friendly into the enemy-damage accumulator, 8 bits, saturating at 8'hFF.
REQ-021 Dead slots SHALL contribute neither position nor damage.
REQ-022 The accumulators SHALL be cleared on entry to SCAN: max=0, min=9'h1FF, sums=0, no index found.
REQ-023 On the SCAN->APPLY edge, the module SHALL load enemyFront, unitFront, unitDamageIn, enemyDamageIn, unitHit and enemyHit from the accumulators.
REQ-024 When no alive friendly is found, unitHit SHALL be 0 and unitFront SHALL be 9'h1FF.
REQ-025 When no alive enemy is found, enemyHit SHALL be 0 and enemyFront SHALL be 9'h000.
REQ-026 APPLY SHALL be exactly 1 cycle with damageSCEN=1, then go to MOVE.
REQ-027 MOVE SHALL be exactly 1 cycle with moveSCEN=1, then go to IDLE.
REQ-028 damageSCEN and moveSCEN SHALL never be high in the same cycle.
REQ-029 The round period with run held high SHALL be TICK_DIV+N_UNITS+2 cycles.
REQ-030 Fronts, damages and hits SHALL hold their values between rounds.
REQ-031 Once a round has left IDLE, it SHALL complete regardless of run.
REQ-032 Slot inputs that change during SCAN SHALL be sampled only when their idx is examined; no re-scan SHALL occur.

Reset
REQ-033 When reset=1 at a clk edge, the module SHALL enter IDLE with counter=0, idx=0, enemyFront=0, unitFront=9'h1FF, both damages 0, both hit vectors 0, damageSCEN=0 and moveSCEN=0.
REQ-034 Reset SHALL take priority over all other activity and SHALL abort any in-progress round, with no strobe emitted in the next cycle.

Structure
REQ-035 A shared package SHALL hold: the state encoding; POS_W=9, DMG_W=8 and TYPE_W=2; TYPE_DEAD=2'b00; POS_MAX=9'h1FF.
REQ-036 One sub-module, sat_add8, SHALL provide the 8-bit saturating adder and SHALL be instantiated twice.
REQ-037 No other sub-modules SHALL be used.

Verification
REQ-038 Test: run=1, N_UNITS=4, TICK_DIV=8, all slots dead; required response: damageSCEN at cycle 13 after reset release, moveSCEN at cycle 14, enemyFront=0, unitFront=0x1FF, hits=0.
REQ-039 Test: enemies alive at 10, 40, 40, 5 and friendlies alive at 300, 200, 200, 511; required response: enemyFront=40, enemyHit=4'b0010, unitFront=200, unitHit=4'b0010.
REQ-040 Test: enemyDamageOut of 0x80, 0x80 and 0x10, all alive; required response: unitDamageIn=0xFF (saturated); the same with enemy slot 1 dead gives 0x90.
REQ-041 Test: run dropped for 20 cycles in IDLE at counter=3; required response: no strobes during the drop, and damageSCEN arrives exactly 4+4+1 cycles after run returns high.
REQ-042 Test: run dropped during SCAN; required response: the round completes and APPLY and MOVE both occur.
REQ-043 Test: reset asserted during SCAN at idx=2; required response: next cycle IDLE, no damageSCEN, all outputs at reset values.

Source files
------------

// File: rtl/battlefront_calc_pkg.sv
// Shared types and constants for the battlefront round calculator.
// Slot field widths, the dead-slot type code and the FSM state encoding.
package battlefront_calc_pkg;

  localparam int POS_W  = 9;
  localparam int DMG_W  = 8;
  localparam int TYPE_W = 2;

  localparam logic [TYPE_W-1:0] TYPE_DEAD = 2'b00;
  localparam logic [POS_W-1:0]  POS_MAX   = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2,
    MOVE  = 2'd3
  } state_t;

endpackage

// File: rtl/battlefront_calc_if.sv
// Bundle of slot inputs and round results exchanged with battlefront_calc.
// The master side drives slot data and run; the slave side returns results.
interface battlefront_calc_if
  import battlefront_calc_pkg::*;
#(
  parameter int N_UNITS = 4
) (
  input logic clk
);

  logic                        run;
  logic [N_UNITS*POS_W-1:0]    unit_position;
  logic [N_UNITS*TYPE_W-1:0]   unit_type;
  logic [N_UNITS*DMG_W-1:0]    unit_damage_out;
  logic [N_UNITS*POS_W-1:0]    enemy_position;
  logic [N_UNITS*TYPE_W-1:0]   enemy_type;
  logic [N_UNITS*DMG_W-1:0]    enemy_damage_out;

  logic [POS_W-1:0]            enemy_front;
  logic [POS_W-1:0]            unit_front;
  logic [DMG_W-1:0]            unit_damage_in;
  logic [DMG_W-1:0]            enemy_damage_in;
  logic [N_UNITS-1:0]          unit_hit;
  logic [N_UNITS-1:0]          enemy_hit;
  logic                        damage_scen;
  logic                        move_scen;

  modport master (
    input  clk,
    output run, unit_position, unit_type, unit_damage_out,
    output enemy_position, enemy_type, enemy_damage_out,
    input  enemy_front, unit_front, unit_damage_in, enemy_damage_in,
    input  unit_hit, enemy_hit, damage_scen, move_scen
  );

  modport slave (
    input  clk,
    input  run, unit_position, unit_type, unit_damage_out,
    input  enemy_position, enemy_type, enemy_damage_out,
    output enemy_front, unit_front, unit_damage_in, enemy_damage_in,
    output unit_hit, enemy_hit, damage_scen, move_scen
  );

endinterface

// File: rtl/battlefront_calc_sat_add8.sv
// Combinational 8-bit adder that clamps to 8'hFF on overflow.
module sat_add8
  import battlefront_calc_pkg::*;
(
  input  logic [DMG_W-1:0] a,
  input  logic [DMG_W-1:0] b,
  output logic [DMG_W-1:0] sum
);

  logic [DMG_W:0] wide;

  assign wide = {1'b0, a} + {1'b0, b};
  assign sum  = wide[DMG_W] ? {DMG_W{1'b1}} : wide[DMG_W-1:0];

endmodule

// File: rtl/battlefront_calc.sv
// Periodic combat round: scans slot pairs one per cycle for the fronts and
// summed damage, then pulses damage and move strobes on consecutive cycles.
module battlefront_calc
  import battlefront_calc_pkg::*;
#(
  parameter int N_UNITS  = 4,
  parameter int TICK_DIV = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic [N_UNITS*POS_W-1:0]  unitPosition,
  input  logic [N_UNITS*TYPE_W-1:0] unitType,
  input  logic [N_UNITS*DMG_W-1:0]  unitDamageOut,
  input  logic [N_UNITS*POS_W-1:0]  enemyPosition,
  input  logic [N_UNITS*TYPE_W-1:0] enemyType,
  input  logic [N_UNITS*DMG_W-1:0]  enemyDamageOut,
  output logic [POS_W-1:0]          enemyFront,
  output logic [POS_W-1:0]          unitFront,
  output logic [DMG_W-1:0]          unitDamageIn,
  output logic [DMG_W-1:0]          enemyDamageIn,
  output logic [N_UNITS-1:0]        unitHit,
  output logic [N_UNITS-1:0]        enemyHit,
  output logic                      damageSCEN,
  output logic                      moveSCEN
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_UNITS - 1);

  logic [POS_W-1:0] u_pos [N_UNITS];
  logic [POS_W-1:0] e_pos [N_UNITS];
  logic [DMG_W-1:0] u_dmg [N_UNITS];
  logic [DMG_W-1:0] e_dmg [N_UNITS];
  logic [N_UNITS-1:0] u_alive;
  logic [N_UNITS-1:0] e_alive;

  for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_slot
    assign u_pos[gi]   = unitPosition[gi*POS_W +: POS_W];
    assign e_pos[gi]   = enemyPosition[gi*POS_W +: POS_W];
    assign u_dmg[gi]   = unitDamageOut[gi*DMG_W +: DMG_W];
    assign e_dmg[gi]   = enemyDamageOut[gi*DMG_W +: DMG_W];
    assign u_alive[gi] = (unitType[gi*TYPE_W +: TYPE_W] != TYPE_DEAD);
    assign e_alive[gi] = (enemyType[gi*TYPE_W +: TYPE_W] != TYPE_DEAD);
  end

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [POS_W-1:0] emax_reg, emax_next;
  logic [IDX_W-1:0] emax_idx_reg, emax_idx_next;
  logic             emax_found_reg, emax_found_next;
  logic [POS_W-1:0] umin_reg, umin_next;
  logic [IDX_W-1:0] umin_idx_reg, umin_idx_next;
  logic             umin_found_reg, umin_found_next;
  logic [DMG_W-1:0] unit_sum_reg, unit_sum_next;
  logic [DMG_W-1:0] enemy_sum_reg, enemy_sum_next;

  logic [POS_W-1:0]   enemy_front_reg, enemy_front_next;
  logic [POS_W-1:0]   unit_front_reg, unit_front_next;
  logic [DMG_W-1:0]   unit_dmg_in_reg, unit_dmg_in_next;
  logic [DMG_W-1:0]   enemy_dmg_in_reg, enemy_dmg_in_next;
  logic [N_UNITS-1:0] unit_hit_reg, unit_hit_next;
  logic [N_UNITS-1:0] enemy_hit_reg, enemy_hit_next;
  logic               damage_scen_reg, damage_scen_next;
  logic               move_scen_reg, move_scen_next;

  // Slot pair currently under examination; dead slots feed zero damage.
  logic             cur_u_alive, cur_e_alive;
  logic [POS_W-1:0] cur_u_pos, cur_e_pos;
  logic [DMG_W-1:0] cur_u_dmg, cur_e_dmg;
  logic [DMG_W-1:0] unit_sum_add, enemy_sum_add;

  assign cur_u_alive = u_alive[idx_reg];
  assign cur_e_alive = e_alive[idx_reg];
  assign cur_u_pos   = u_pos[idx_reg];
  assign cur_e_pos   = e_pos[idx_reg];
  assign cur_u_dmg   = cur_u_alive ? u_dmg[idx_reg] : '0;
  assign cur_e_dmg   = cur_e_alive ? e_dmg[idx_reg] : '0;

  sat_add8 u_unit_add (
    .a   (unit_sum_reg),
    .b   (cur_e_dmg),
    .sum (unit_sum_add)
  );

  sat_add8 u_enemy_add (
    .a   (enemy_sum_reg),
    .b   (cur_u_dmg),
    .sum (enemy_sum_add)
  );

  always_comb begin
    state_next        = state_reg;
    counter_next      = counter_reg;
    idx_next          = idx_reg;
    emax_next         = emax_reg;
    emax_idx_next     = emax_idx_reg;
    emax_found_next   = emax_found_reg;
    umin_next         = umin_reg;
    umin_idx_next     = umin_idx_reg;
    umin_found_next   = umin_found_reg;
    unit_sum_next     = unit_sum_reg;
    enemy_sum_next    = enemy_sum_reg;
    enemy_front_next  = enemy_front_reg;
    unit_front_next   = unit_front_reg;
    unit_dmg_in_next  = unit_dmg_in_reg;
    enemy_dmg_in_next = enemy_dmg_in_reg;
    unit_hit_next     = unit_hit_reg;
    enemy_hit_next    = enemy_hit_reg;
    damage_scen_next  = 1'b0;
    move_scen_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (run) begin
          if (counter_reg == CNT_LAST) begin
            state_next      = SCAN;
            counter_next    = '0;
            idx_next        = '0;
            emax_next       = '0;
            emax_idx_next   = '0;
            emax_found_next = 1'b0;
            umin_next       = POS_MAX;
            umin_idx_next   = '0;
            umin_found_next = 1'b0;
            unit_sum_next   = '0;
            enemy_sum_next  = '0;
          end else begin
            counter_next = counter_reg + 1'b1;
          end
        end
      end

      SCAN: begin
        // The found flag lets an alive slot win even at the reset extreme.
        if (cur_e_alive && (!emax_found_reg || (cur_e_pos > emax_reg))) begin
          emax_next       = cur_e_pos;
          emax_idx_next   = idx_reg;
          emax_found_next = 1'b1;
        end
        if (cur_u_alive && (!umin_found_reg || (cur_u_pos < umin_reg))) begin
          umin_next       = cur_u_pos;
          umin_idx_next   = idx_reg;
          umin_found_next = 1'b1;
        end
        unit_sum_next  = unit_sum_add;
        enemy_sum_next = enemy_sum_add;

        if (idx_reg == IDX_LAST) begin
          state_next        = APPLY;
          damage_scen_next  = 1'b1;
          enemy_front_next  = emax_next;
          unit_front_next   = umin_next;
          unit_dmg_in_next  = unit_sum_next;
          enemy_dmg_in_next = enemy_sum_next;
          enemy_hit_next    = emax_found_next ? (N_UNITS'(1) << emax_idx_next) : '0;
          unit_hit_next     = umin_found_next ? (N_UNITS'(1) << umin_idx_next) : '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end

      APPLY: begin
        state_next     = MOVE;
        move_scen_next = 1'b1;
      end

      MOVE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      counter_reg      <= '0;
      idx_reg          <= '0;
      emax_reg         <= '0;
      emax_idx_reg     <= '0;
      emax_found_reg   <= 1'b0;
      umin_reg         <= POS_MAX;
      umin_idx_reg     <= '0;
      umin_found_reg   <= 1'b0;
      unit_sum_reg     <= '0;
      enemy_sum_reg    <= '0;
      enemy_front_reg  <= '0;
      unit_front_reg   <= POS_MAX;
      unit_dmg_in_reg  <= '0;
      enemy_dmg_in_reg <= '0;
      unit_hit_reg     <= '0;
      enemy_hit_reg    <= '0;
      damage_scen_reg  <= 1'b0;
      move_scen_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      counter_reg      <= counter_next;
      idx_reg          <= idx_next;
      emax_reg         <= emax_next;
      emax_idx_reg     <= emax_idx_next;
      emax_found_reg   <= emax_found_next;
      umin_reg         <= umin_next;
      umin_idx_reg     <= umin_idx_next;
      umin_found_reg   <= umin_found_next;
      unit_sum_reg     <= unit_sum_next;
      enemy_sum_reg    <= enemy_sum_next;
      enemy_front_reg  <= enemy_front_next;
      unit_front_reg   <= unit_front_next;
      unit_dmg_in_reg  <= unit_dmg_in_next;
      enemy_dmg_in_reg <= enemy_dmg_in_next;
      unit_hit_reg     <= unit_hit_next;
      enemy_hit_reg    <= enemy_hit_next;
      damage_scen_reg  <= damage_scen_next;
      move_scen_reg    <= move_scen_next;
    end
  end

  assign enemyFront    = enemy_front_reg;
  assign unitFront     = unit_front_reg;
  assign unitDamageIn  = unit_dmg_in_reg;
  assign enemyDamageIn = enemy_dmg_in_reg;
  assign unitHit       = unit_hit_reg;
  assign enemyHit      = enemy_hit_reg;
  assign damageSCEN    = damage_scen_reg;
  assign moveSCEN      = move_scen_reg;

endmodule
